fft_tw_sched: RTL and testbench

//  Sequencer for an in-place radix-2 DIT FFT. Walks all stages and butterflies, drives the twiddle ROM
//  (1-cycle registered read, output held while rd_en=0), and emits the per-butterfly index pair plus twiddle
//  to the butterfly datapath over a valid/ready handshake. Sits between the FFT top-level control and the BF unit.

---
 rtl/fft_tw_sched.sv | 167 ++++++++++++++++
 tb/tb_fft_tw_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_tw_sched.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT: drives the twiddle ROM and issues descriptors.
// Optional FFT_TW_SCHED_BARRIER_EN: pause between stages until stage_go releases the next stage.
module fft_tw_sched #(
    parameter int N_LOG2     = 9,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_real,
    input  logic [DATA_WIDTH-1:0] rom_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_LOG2-1:0]     out_stage,
    output logic [N_LOG2-1:0]     out_idx_a,
    output logic [N_LOG2-1:0]     out_idx_b,
    output logic [DATA_WIDTH-1:0] out_tw_real,
    output logic [DATA_WIDTH-1:0] out_tw_imag,
    input  logic                  stage_go
);

    localparam int KW = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, BARRIER} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [N_LOG2-1:0] s_q, s_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [N_LOG2-1:0] stage_q, stage_d;
    logic [N_LOG2-1:0] idx_a_q, idx_a_d;
    logic [N_LOG2-1:0] idx_b_q, idx_b_d;

    logic              issue;
    logic              accept;
    logic              last_k;
    logic              last_s;
    logic [N_LOG2-1:0] k_ext;
    logic [N_LOG2-1:0] mask;
    logic [N_LOG2-1:0] j_c;
    logic [N_LOG2-1:0] idx_a_c;
    logic [N_LOG2-1:0] idx_b_c;
    logic [N_LOG2-1:0] tw_c;

    // mask = h-1; idx_a spreads k around the h-wide gap: the group bits move up by one.
    always_comb begin
        k_ext   = N_LOG2'(k_q);
        mask    = (N_LOG2'(1) << s_q) - N_LOG2'(1);
        j_c     = k_ext & mask;
        idx_a_c = ((k_ext & ~mask) << 1) | j_c;
        idx_b_c = idx_a_c | (mask + N_LOG2'(1));
        tw_c    = j_c << (N_LOG2'(N_LOG2 - 1) - s_q);
    end

    assign issue  = (state_q == RUN) && (!valid_q || out_ready);
    assign accept = valid_q && out_ready;
    assign last_k = (k_q == {KW{1'b1}});
    assign last_s = (s_q == N_LOG2'(N_LOG2 - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        stage_d = stage_q;
        idx_a_d = idx_a_q;
        idx_b_d = idx_b_q;

        if (issue) begin
            valid_d = 1'b1;
            stage_d = s_q;
            idx_a_d = idx_a_c;
            idx_b_d = idx_b_c;
            k_d     = k_q + KW'(1);
            if (last_k) begin
                s_d = last_s ? '0 : s_q + N_LOG2'(1);
`ifdef FFT_TW_SCHED_BARRIER_EN
                state_d = DRAIN;
`else
                if (last_s) state_d = DRAIN;
`endif
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (accept) begin
`ifdef FFT_TW_SCHED_BARRIER_EN
                    if (stage_q == N_LOG2'(N_LOG2 - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BARRIER;
                    end
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
            BARRIER: begin
                if (stage_go) state_d = RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            stage_q <= '0;
            idx_a_q <= '0;
            idx_b_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            stage_q <= stage_d;
            idx_a_q <= idx_a_d;
            idx_b_q <= idx_b_d;
        end
    end

`ifndef FFT_TW_SCHED_BARRIER_EN
    logic unused_stage_go;
    assign unused_stage_go = stage_go;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign rom_rd_en   = issue;
    assign rom_addr    = ADDR_WIDTH'(tw_c[KW-1:0]);
    assign out_valid   = valid_q;
    assign out_stage   = stage_q;
    assign out_idx_a   = idx_a_q;
    assign out_idx_b   = idx_b_q;
    assign out_tw_real = rom_real;
    assign out_tw_imag = rom_imag;

endmodule

// File: tb/tb_fft_tw_sched.sv
// Bench for fft_tw_sched at N=8: descriptor scoreboard built from the butterfly formulas plus directed scenarios.
module tb_fft_tw_sched;
    localparam int NL = 3;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int NDESC = NL * (1 << (NL - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rom_rd_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_real;
    logic [DW-1:0] rom_imag;
    logic          out_valid;
    logic          out_ready;
    logic [NL-1:0] out_stage;
    logic [NL-1:0] out_idx_a;
    logic [NL-1:0] out_idx_b;
    logic [DW-1:0] out_tw_real;
    logic [DW-1:0] out_tw_imag;
    logic          stage_go;

    int tests = 0;
    int fails = 0;
    int ptr = 0;
    int done_cnt = 0;
    int e_s[NDESC];
    int e_a[NDESC];
    int e_b[NDESC];
    int e_tw[NDESC];

    fft_tw_sched #(.N_LOG2(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_real(rom_real), .rom_imag(rom_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_stage(out_stage),
        .out_idx_a(out_idx_a), .out_idx_b(out_idx_b),
        .out_tw_real(out_tw_real), .out_tw_imag(out_tw_imag), .stage_go(stage_go)
    );

    always #5 clk = ~clk;

    // Twiddle ROM stand-in: registered read, data held while rd_en is low.
    always @(posedge clk) begin
        if (rom_rd_en) begin
            rom_real <= DW'(rom_addr);
            rom_imag <= ~DW'(rom_addr);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / stability monitor, sampled mid-cycle.
    logic          held = 1'b0;
    logic [NL-1:0] h_s, h_a, h_b;
    logic [DW-1:0] h_r;
    always @(negedge clk) begin
        if (rst) begin
            ptr  = 0;
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_stage", int'(out_stage), int'(h_s));
                chk("hold_idx_a", int'(out_idx_a), int'(h_a));
                chk("hold_idx_b", int'(out_idx_b), int'(h_b));
                chk("hold_tw", int'(out_tw_real), int'(h_r));
            end
            held = out_valid && !out_ready;
            h_s = out_stage; h_a = out_idx_a; h_b = out_idx_b; h_r = out_tw_real;
            if (out_valid && !out_ready) chk("stall_rd_en", int'(rom_rd_en), 0);
            if (out_valid && out_ready) begin
                if (ptr >= NDESC) begin
                    timeout("extra_descriptor");
                end else begin
                    chk("desc_stage", int'(out_stage), e_s[ptr]);
                    chk("desc_idx_a", int'(out_idx_a), e_a[ptr]);
                    chk("desc_idx_b", int'(out_idx_b), e_b[ptr]);
                    chk("desc_tw_re", int'(out_tw_real), e_tw[ptr]);
                    chk("desc_tw_im", int'(out_tw_imag), (1 << DW) - 1 - e_tw[ptr]);
                end
                $display("[TB] desc %0d s=%0d a=%0d b=%0d tw=%0d", ptr, out_stage, out_idx_a, out_idx_b, out_tw_real);
                ptr++;
            end
            if (done) begin
                chk("done_all_accepted", ptr, NDESC);
                done_cnt++;
            end
            if (start && !busy) ptr = 0;
        end
    end

    task automatic wait_ptr(input int n, input bit need_valid);
        int c;
        for (c = 0; c < 200; c++) begin
            if (ptr == n && (out_valid || !need_valid)) break;
            step();
        end
        if (c == 200) timeout("wait_ptr");
    endtask

    task automatic wait_done();
        int c;
        for (c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) break;
            #1;
        end
        if (c == 300) timeout("wait_done");
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int d0;
        // Expected descriptor order from the butterfly formulas.
        for (int s = 0; s < NL; s++) begin
            for (int k = 0; k < (1 << (NL - 1)); k++) begin
                int h, n;
                h = 1 << s;
                n = s * (1 << (NL - 1)) + k;
                e_s[n]  = s;
                e_a[n]  = (k / h) * 2 * h + (k % h);
                e_b[n]  = e_a[n] + h;
                e_tw[n] = (k % h) * (1 << (NL - 1 - s));
            end
        end
        chk("model_d5_a", e_a[5], 1);
        chk("model_d5_b", e_b[5], 3);
        chk("model_d5_tw", e_tw[5], 2);
        chk("model_d11_a", e_a[11], 3);
        chk("model_d11_b", e_b[11], 7);
        chk("model_d11_tw", e_tw[11], 3);

        rst = 1'b1; start = 1'b0; out_ready = 1'b1; stage_go = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rom_rd_en), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_stage", int'(out_stage), 0);
        chk("rst_idx_a", int'(out_idx_a), 0);
        chk("rst_idx_b", int'(out_idx_b), 0);
        step();
        rst = 1'b0;
        step();

        // Full run at full throughput.
        d0 = done_cnt;
`ifdef FFT_TW_SCHED_BARRIER_EN
        do_start();
        wait_done();
`else
        start = 1'b1;
        @(negedge clk);
        chk("c0_busy", int'(busy), 0);
        step();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("cyc_valid", int'(out_valid), (c >= 2 && c <= 13) ? 1 : 0);
            chk("cyc_done", int'(done), (c == 14) ? 1 : 0);
            chk("cyc_busy", int'(busy), (c <= 13) ? 1 : 0);
            if (c == 2) begin
                chk("c2_idx_a", int'(out_idx_a), 0);
                chk("c2_idx_b", int'(out_idx_b), 1);
            end
            if (c == 7) begin
                chk("c7_idx_a", int'(out_idx_a), 1);
                chk("c7_idx_b", int'(out_idx_b), 3);
                chk("c7_tw", int'(out_tw_real), 2);
            end
            if (c == 13) begin
                chk("c13_idx_a", int'(out_idx_a), 3);
                chk("c13_idx_b", int'(out_idx_b), 7);
                chk("c13_tw", int'(out_tw_real), 3);
            end
            step();
        end
`endif
        chk("run1_dones", done_cnt - d0, 1);

        // Backpressure on the 5th descriptor.
        d0 = done_cnt;
        do_start();
        wait_ptr(4, 1'b1);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_rd_en", int'(rom_rd_en), 0);
            chk("bp_stage", int'(out_stage), 1);
            chk("bp_idx_a", int'(out_idx_a), 0);
            chk("bp_idx_b", int'(out_idx_b), 2);
            chk("bp_tw", int'(out_tw_real), 0);
            step();
        end
        out_ready = 1'b1;
        wait_done();
        chk("bp_dones", done_cnt - d0, 1);

        // Random backpressure.
        d0 = done_cnt;
        do_start();
        for (int c = 0; c < 300 && done_cnt == d0; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        out_ready = 1'b1;
        repeat (5) step();
        chk("rnd_dones", done_cnt - d0, 1);
        chk("rnd_count", ptr, NDESC);

        // start while busy is ignored.
        d0 = done_cnt;
        do_start();
        wait_ptr(5, 1'b1);
        do_start();
        wait_done();
        repeat (5) step();
        chk("sib_dones", done_cnt - d0, 1);
        chk("sib_count", ptr, NDESC);
        chk("sib_busy", int'(busy), 0);

        // Asynchronous reset mid-run.
        d0 = done_cnt;
        do_start();
        wait_ptr(6, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_rd_en", int'(rom_rd_en), 0);
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("arst_no_done", done_cnt - d0, 0);
        do_start();
        wait_ptr(0, 1'b1);
        chk("replay_idx_a", int'(out_idx_a), 0);
        chk("replay_idx_b", int'(out_idx_b), 1);
        wait_done();
        chk("replay_dones", done_cnt - d0, 1);

`ifdef FFT_TW_SCHED_BARRIER_EN
        d0 = done_cnt;
        stage_go = 1'b0;
        do_start();
        wait_ptr(4, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bar_valid", int'(out_valid), 0);
            chk("bar_rd_en", int'(rom_rd_en), 0);
            step();
        end
        stage_go = 1'b1;
        wait_ptr(4, 1'b1);
        chk("bar_stage", int'(out_stage), 1);
        chk("bar_idx_a", int'(out_idx_a), 0);
        chk("bar_idx_b", int'(out_idx_b), 2);
        wait_done();
        chk("bar_dones", done_cnt - d0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
